// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the HI/LO pair: MUL_LAT-cycle multiply,
// WIDTH-step restoring divide plus a sign-fix cycle, start/busy/done handshake and cancel.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_r, state_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic               signed_r, neg_q_r, neg_r_r;
    logic [WIDTH-1:0]   a_r, b_r, quo_r, rem_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r, dbz_r;

    logic               accept_s, write_s, ge_s, wr_dbz_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH-1:0]   sub_s, wr_hi_s, wr_lo_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = ~v + WIDTH'(1);
        end else begin
            magnitude = v;
        end
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state; cancel wins over every transition, including the write edge
    always_comb begin
        state_nx = state_r;
        accept_s = 1'b0;
        write_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !cancel) begin
                    accept_s = 1'b1;
                    if (op == OP_MULT || op == OP_MULTU) begin
                        state_nx = MUL;
                    end else if (op == OP_DIV || op == OP_DIVU) begin
                        state_nx = DIV;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            MUL: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (cnt_r == MUL_LAST) begin
                    write_s  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = MUL;
                end
            end
            DIV: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (cnt_r == DIV_LAST) begin
                    state_nx = FIX;
                end else begin
                    state_nx = DIV;
                end
            end
            FIX: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else begin
                    write_s  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Product of the latched operands (sign-extended for MULT) and one restoring-divide step
    always_comb begin
        prod_s   = {{WIDTH{signed_r & a_r[WIDTH-1]}}, a_r} * {{WIDTH{signed_r & b_r[WIDTH-1]}}, b_r};
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        ge_s     = (rem_sh_s >= {1'b0, b_r});
        sub_s    = rem_sh_s[WIDTH-1:0] - b_r;
    end

    // Result selection; b_r holds the divisor magnitude while dividing, so zero means divide-by-zero
    always_comb begin
        wr_hi_s  = hi_r;
        wr_lo_s  = lo_r;
        wr_dbz_s = 1'b0;
        if (state_r == FIX) begin
            if (b_r == {WIDTH{1'b0}}) begin
                wr_hi_s  = a_r;
                wr_lo_s  = {WIDTH{1'b1}};
                wr_dbz_s = 1'b1;
            end else begin
                wr_hi_s  = neg_r_r ? (~rem_r + WIDTH'(1)) : rem_r;
                wr_lo_s  = neg_q_r ? (~quo_r + WIDTH'(1)) : quo_r;
                wr_dbz_s = 1'b0;
            end
        end else begin
            wr_hi_s  = prod_s[2*WIDTH-1:WIDTH];
            wr_lo_s  = prod_s[WIDTH-1:0];
            wr_dbz_s = 1'b0;
        end
    end

    // Operand latch, iteration counter, divide datapath and the architectural HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_W'(0);
            signed_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= write_s;
            busy_r <= (state_nx != IDLE);
            if (accept_s) begin
                cnt_r    <= CNT_W'(0);
                a_r      <= src_a;
                signed_r <= (op == OP_MULT) || (op == OP_DIV);
                neg_q_r  <= (op == OP_DIV) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r_r  <= (op == OP_DIV) && src_a[WIDTH-1];
                rem_r    <= {WIDTH{1'b0}};
                if (op == OP_DIV || op == OP_DIVU) begin
                    b_r   <= magnitude(src_b, op == OP_DIV);
                    quo_r <= magnitude(src_a, op == OP_DIV);
                end else begin
                    b_r <= src_b;
                end
                if (op == OP_MTHI) begin
                    hi_r <= src_a;
                end else if (op == OP_MTLO) begin
                    lo_r <= src_a;
                end
            end else if (state_r == MUL || state_r == DIV) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r == DIV) begin
                if (ge_s) begin
                    rem_r <= sub_s;
                    quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                end else begin
                    rem_r <= rem_sh_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                end
            end
            if (write_s) begin
                hi_r  <= wr_hi_s;
                lo_r  <= wr_lo_s;
                dbz_r <= wr_dbz_s;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_by_0 = dbz_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule
